// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: play-state sequencer, jump arc, obstacle spawn timer and score counter.
// Rev 1.0
`default_nettype none

module dino_game_ctrl #(
  parameter int JUMP_H    = 40,
  parameter int JUMP_STEP = 4,
  parameter int SPAWN_MIN = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_pulse,
  input  logic        jump_pulse,
  input  logic [6:0]  rnd,
  input  logic        collide,
  output logic [1:0]  state,
  output logic [5:0]  dino_y,
  output logic        rising,
  output logic        spawn,
  output logic [13:0] score
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [6:0]  SPAWN_MIN_W = 7'(SPAWN_MIN);
  localparam logic [6:0]  STEP_W      = 7'(JUMP_STEP);
  localparam logic [5:0]  STEP6       = 6'(JUMP_STEP);
  localparam logic [6:0]  JUMP_H_W    = 7'(JUMP_H);
  localparam logic [5:0]  JUMP_H6     = 6'(JUMP_H);
  localparam logic [13:0] SCORE_MAX   = 14'd9999;

  state_t      cur_state, nxt_state;
  logic [5:0]  nxt_y;
  logic        nxt_rising;
  logic        nxt_spawn;
  logic [13:0] nxt_score;
  logic [6:0]  cnt, nxt_cnt;
  logic [6:0]  reload;
  logic [6:0]  y_up;

  // Masking keeps only rnd[5:0] while every input bit stays referenced.
  assign reload = SPAWN_MIN_W + (rnd & 7'h3F);
  assign y_up   = {1'b0, dino_y} + STEP_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      dino_y    <= '0;
      rising    <= 1'b0;
      spawn     <= 1'b0;
      score     <= '0;
      cnt       <= '0;
    end else begin
      cur_state <= nxt_state;
      dino_y    <= nxt_y;
      rising    <= nxt_rising;
      spawn     <= nxt_spawn;
      score     <= nxt_score;
      cnt       <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    nxt_y      = dino_y;
    nxt_rising = rising;
    nxt_spawn  = 1'b0;
    nxt_score  = score;
    nxt_cnt    = cnt;

    case (cur_state)
      IDLE, OVER: begin
        if (start_pulse) begin
          nxt_state  = RUN;
          nxt_y      = '0;
          nxt_rising = 1'b0;
          nxt_score  = '0;
          nxt_cnt    = reload;
        end
      end

      RUN, JUMP: begin
        // Collision wins over everything else in the same cycle.
        if (collide) begin
          nxt_state = OVER;
        end else begin
          if (tick) begin
            if (score != SCORE_MAX) nxt_score = score + 14'd1;
            if (cnt == 7'd1) begin
              nxt_spawn = 1'b1;
              nxt_cnt   = reload;
            end else if (cnt != 7'd0) begin
              nxt_cnt = cnt - 7'd1;
            end
          end

          if (cur_state == RUN) begin
            if (jump_pulse) begin
              nxt_state  = JUMP;
              nxt_rising = 1'b1;
            end
          end else if (tick) begin
            if (rising) begin
              if (y_up >= JUMP_H_W) begin
                nxt_y      = JUMP_H6;
                nxt_rising = 1'b0;
              end else begin
                nxt_y = y_up[5:0];
              end
            end else if (dino_y <= STEP6) begin
              nxt_y     = '0;
              nxt_state = RUN;
            end else begin
              nxt_y = dino_y - STEP6;
            end
          end
        end
      end

      default: nxt_state = IDLE;
    endcase
  end

  assign state = cur_state;

endmodule

`default_nettype wire

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Game-flow controller for the dino runner. It sequences the play states, the dino jump arc, obstacle spawn timing and the score counter. It consumes single-cycle button pulses (debounced and one-pulsed upstream), a per-frame tick enable and the free-running 1..98 random value. It drives the renderer, the obstacle generator and the score display.

## Interface
- JUMP_H, 40: jump apex height in pixels; 1..63.
- JUMP_STEP, 4: pixels moved per tick while jumping; 1..JUMP_H.
- SPAWN_MIN, 30: minimum ticks between spawns; 1..64.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  frame enable, high for exactly one clk cycle per frame.
- start_pulse  in  1  single-cycle start/restart request.
- jump_pulse  in  1  single-cycle jump request.
- rnd  in  7  random value, 1..98; only rnd[5:0] is used.
- collide  in  1  dino/obstacle overlap flag, level.
- state  out  2  0 IDLE, 1 RUN, 2 JUMP, 3 OVER.
- dino_y  out  6  dino height above ground, 0..JUMP_H.
- rising  out  1  1 while the jump is ascending.
- spawn  out  1  single-cycle request to launch an obstacle.
- score  out  14  ticks survived, binary, saturates at 9999.

## Operation
- Reset values: state=IDLE, dino_y=0, rising=0, spawn=0, score=0. The internal spawn countdown (7 bits) resets to 0.
- IDLE
  - All outputs hold.
  - start_pulse → RUN, score=0, dino_y=0, countdown=SPAWN_MIN+rnd[5:0].
- RUN, on each tick:
  - score+1, saturating at 9999.
  - Countdown decrements.
  - If the countdown is 1 at the tick: spawn=1 on the next cycle, and the countdown reloads with SPAWN_MIN+rnd[5:0] sampled in that cycle.
- RUN → JUMP
  - jump_pulse → JUMP with rising=1. This does not wait for a tick.
- JUMP
  - Score and spawn logic run exactly as in RUN.
  - On tick while rising:
    - If dino_y+JUMP_STEP ≥ JUMP_H: dino_y=JUMP_H and rising=0.
    - Otherwise: dino_y+=JUMP_STEP.
  - On tick while falling:
    - If dino_y ≤ JUMP_STEP: dino_y=0 and state=RUN.
    - Otherwise: dino_y-=JUMP_STEP.
  - jump_pulse is ignored (no double jump).
- Collision
  - collide=1 in RUN or JUMP → OVER on the next edge.
  - dino_y, rising and score freeze at their pre-collision values.
  - A tick in the same cycle as collide has no effect: no score increment, no height change, no spawn.
  - collide is ignored in IDLE and OVER.
- OVER
  - All outputs hold and spawn=0.
  - start_pulse → RUN with score=0, dino_y=0, rising=0, and the countdown reloaded.
- start_pulse is ignored in RUN and JUMP.
- jump_pulse is ignored in IDLE and OVER.
- spawn is never 1 outside RUN and JUMP, and never for more than one consecutive cycle.
- jump_pulse and tick in the same RUN cycle: the transition to JUMP takes effect, the tick is applied with RUN semantics, and dino_y stays 0 for that tick.
- Width rule: SPAWN_MIN+63 ≤ 127, so the countdown never overflows. Score arithmetic is 14 bits wide, with saturation checked before the add.

## Timing
- All outputs are registered, with one clk latency from the causing input.
- spawn appears one cycle after the qualifying tick.
- A jump lasts 2·⌈JUMP_H/JUMP_STEP⌉ ticks; the defaults give 20.
- Reset asserted mid-jump or in OVER forces all reset values immediately, without waiting for clk.
- After rst deasserts, the first action needs start_pulse.

## Test plan
- Reset, then start_pulse, then 100 ticks: state=RUN, score=100, dino_y=0.
- rnd=37 held at start: countdown=67, and spawn pulses exactly once, one cycle after the 67th tick. The next spawn follows 67 ticks later.
- jump_pulse in RUN, then ticks:
  - dino_y steps 4,8,…,40 over 10 ticks and rising drops at 40.
  - It then steps 36,…,0 over 10 ticks and state returns to RUN.
  - A jump_pulse at tick 5 has no effect.
- collide raised at jump tick 3 (dino_y=12) together with a tick: state=OVER next cycle, dino_y=12, score not incremented, no spawn afterwards.
- Preload near the limit, then 10 ticks from score 9995: score holds at 9999.
- rst pulsed mid-jump between clk edges: outputs are immediately IDLE, 0, 0, 0, 0; start_pulse in OVER restarts with score=0.
